// File: rtl/i2c_pkg.sv
// Shared I2C definitions: arbiter FSM encoding, bus field widths and
// response flag bit positions used by the arbiter, master engine and write path.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam int RESP_FLAG_NACK    = 0;
    localparam int RESP_FLAG_TIMEOUT = 1;
    localparam int RESP_FLAG_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RUN,
        ST_RESP,
        ST_GAP
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping around, reported as one-hot grant plus binary index.
module i2c_rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] pos_arr [NREQ];
    logic [NREQ-1:0]  hit;

    // pos_arr[gi] is the client sitting gi places after ptr
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDX_W:0] pos_sum;
            assign pos_sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign pos_arr[gi] = IDX_W'((pos_sum >= (IDX_W+1)'(NREQ)) ?
                                        pos_sum - (IDX_W+1)'(NREQ) : pos_sum);
            assign hit[gi]     = req[pos_arr[gi]];
        end
    endgenerate

    always_comb begin
        grant = '0;
        index = '0;
        any   = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                index = pos_arr[k];
            end
        end
        if (any) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte-transaction engine between NREQ
// clients: grant, latch request, run engine with timeout, respond, bus-free gap.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [I2C_ADDR_W*NREQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]            req_rw,
    output logic [NREQ-1:0]            gnt,
    output logic                       resp_valid,
    output logic [$clog2(NREQ)-1:0]    resp_id,
    output logic                       resp_nack,
    output logic                       resp_timeout,
    output logic [I2C_DATA_W-1:0]      resp_rdata,
    output logic [I2C_ADDR_W-1:0]      m_addr,
    output logic [I2C_DATA_W-1:0]      m_data,
    output logic                       m_rw,
    output logic                       m_enable,
    input  logic                       m_done,
    input  logic                       m_nack,
    input  logic [I2C_DATA_W-1:0]      m_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    arb_state_t state_reg, state_next;

    logic [NREQ-1:0]        gnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       ptr_reg;
    logic [TO_W-1:0]        to_cnt_reg;
    logic [GAP_W-1:0]       gap_cnt_reg;
    logic [RESP_FLAG_W-1:0] flags_reg;
    logic [I2C_DATA_W-1:0]  rdata_reg;
    logic [I2C_ADDR_W-1:0]  m_addr_reg;
    logic [I2C_DATA_W-1:0]  m_data_reg;
    logic                   m_rw_reg;

    logic [I2C_ADDR_W-1:0]  addr_arr [NREQ];
    logic [I2C_DATA_W-1:0]  data_arr [NREQ];

    logic [NREQ-1:0]        pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   run_expire;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_arr[gi] = req_addr[I2C_ADDR_W*gi +: I2C_ADDR_W];
            assign data_arr[gi] = req_data[I2C_DATA_W*gi +: I2C_DATA_W];
        end
    endgenerate

    i2c_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign run_expire = (to_cnt_reg == TO_W'(TIMEOUT - 1));

    // m_done wins over the terminal count, so a late completion is a success
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (pick_any) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_RUN;
            ST_RUN:   if (m_done || run_expire) state_next = ST_RESP;
            ST_RESP:  state_next = ST_GAP;
            ST_GAP:   if (gap_cnt_reg == GAP_W'(GAP - 1)) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            ptr_reg     <= '0;
            to_cnt_reg  <= '0;
            gap_cnt_reg <= '0;
            flags_reg   <= '0;
            rdata_reg   <= '0;
            m_addr_reg  <= '0;
            m_data_reg  <= '0;
            m_rw_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    gnt_reg <= pick_gnt;
                    if (pick_any) idx_reg <= pick_idx;
                end
                ST_LATCH: begin
                    m_addr_reg <= addr_arr[idx_reg];
                    m_data_reg <= data_arr[idx_reg];
                    m_rw_reg   <= req_rw[idx_reg];
                    to_cnt_reg <= '0;
                end
                ST_RUN: begin
                    if (m_done) begin
                        flags_reg                 <= '0;
                        flags_reg[RESP_FLAG_NACK] <= m_nack;
                        rdata_reg                 <= m_rdata;
                        gnt_reg                   <= '0;
                    end else if (run_expire) begin
                        flags_reg                    <= '0;
                        flags_reg[RESP_FLAG_TIMEOUT] <= 1'b1;
                        gnt_reg                      <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr_reg     <= (idx_reg == IDX_W'(NREQ - 1)) ? '0 : idx_reg + 1'b1;
                    gap_cnt_reg <= '0;
                end
                ST_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt          = gnt_reg;
    assign m_enable     = (state_reg == ST_RUN);
    assign resp_valid   = (state_reg == ST_RESP);
    assign resp_id      = idx_reg;
    assign resp_nack    = resp_valid & flags_reg[RESP_FLAG_NACK];
    assign resp_timeout = resp_valid & flags_reg[RESP_FLAG_TIMEOUT];
    assign resp_rdata   = rdata_reg;
    assign m_addr       = m_addr_reg;
    assign m_data       = m_data_reg;
    assign m_rw         = m_rw_reg;

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares one I2C master byte-transaction engine between NREQ client requesters. Clients request in round-robin order. The arbiter latches the winner's address, data and R/W, then sequences the engine through one START/address/data/STOP transfer. It returns the result to the winning client and re-arms the engine before the next grant. It sits between the sensor/config clients and the I2C master, on the same clock.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 4096, max cycles allowed from m_enable rise to m_done; width = clog2(TIMEOUT+1)
GAP, 4, idle cycles with m_enable low between transactions (bus-free time), >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NREQ  per-client request level; held until its resp pulse
req_addr  in  7*NREQ  7-bit target address, client i at [7i+6:7i]
req_data  in  8*NREQ  write byte, client i at [8i+7:8i]
req_rw  in  NREQ  0=write, 1=read
gnt  out  NREQ  one-hot; high while client owns the engine
resp_valid  out  1  one-cycle completion pulse
resp_id  out  clog2(NREQ)  client index of the completed transfer
resp_nack  out  1  engine reported NACK (qualified by resp_valid)
resp_timeout  out  1  transfer aborted by timeout (qualified by resp_valid)
resp_rdata  out  8  read byte (valid with resp_valid when rw=1 and no error)
m_addr  out  7  to engine address
m_data  out  8  to engine write byte
m_rw  out  1  to engine R/W
m_enable  out  1  to engine start/hold level
m_done  in  1  engine one-cycle pulse on reaching STOP
m_nack  in  1  engine NACK flag, sampled with m_done
m_rdata  in  8  engine read byte, sampled with m_done

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: gnt=0, resp_valid=0, resp_id=0, resp_nack=0, resp_timeout=0, resp_rdata=0, m_addr=0, m_data=0, m_rw=0, m_enable=0. FSM goes to IDLE, rr pointer=0, counters=0.
- FSM states: IDLE, LATCH, RUN, RESP, GAP.
- IDLE: if any req bit is high, pick the first set bit searching from rr pointer upward with wrap-around. Set gnt one-hot, store index, go to LATCH.
- LATCH (1 cycle): register m_addr/m_data/m_rw from the winner's slice. Clear timeout counter. Next cycle m_enable=1, go to RUN.
- Grant latency: req rise in IDLE -> gnt at +1 cycle -> m_enable at +2 cycles.
- RUN: m_enable held 1. Timeout counter increments each cycle.
  - On m_done: capture m_nack and m_rdata, go to RESP.
  - If counter reaches TIMEOUT-1 with no m_done: set timeout flag, go to RESP.
  - m_done on the same cycle as the timeout terminal count counts as success, not timeout.
- RESP (1 cycle): resp_valid=1, resp_id=index, flags and rdata driven. m_enable=0, gnt cleared. rr pointer = index+1 mod NREQ. Go to GAP.
- GAP: m_enable stays 0 for GAP cycles (counter), then go to IDLE. No grant is issued during GAP.
- Request input changes:
  - The latched request is immune to req/req_addr/req_data changes after LATCH.
  - If the granted client drops req mid-transfer, the transfer still completes and resp_valid still fires.
- m_done outside RUN is ignored.
- resp_rdata holds its last value between pulses. resp_nack and resp_timeout are cleared on every non-RESP cycle.
- Reset asserted mid-transfer: all outputs return to reset values the next cycle, m_enable drops immediately, no resp pulse is produced.
- Fairness: with all clients requesting continuously, grant order is 0,1,...,NREQ-1,0,...; no client waits more than NREQ-1 transfers.

Decomposition:
- Shared package i2c_pkg: FSM state encoding, I2C_ADDR_W=7, I2C_DATA_W=8, and resp flag bit positions. Shared with the master engine and the write-path controller.
- One sub-module: i2c_rr_picker. Combinational priority search from a rotating pointer: inputs req and ptr, outputs one-hot grant, index and any.

Test Plan:
- Single write: reset, req[2]=1, addr 7'h50, data 8'hA5, rw=0 -> gnt=4'b0100 at +1, m_enable at +2 with m_addr=50/m_data=A5; model m_done at +20 -> resp_valid one cycle, resp_id=2, nack=0, timeout=0, then GAP=4 cycles with m_enable=0.
- Round-robin: req=4'b1111 held for 8 transfers -> resp_id sequence 0,1,2,3,0,1,2,3; never two gnt bits set.
- NACK and read: client 1 rw=1; model returns m_nack=0, m_rdata=8'h3C -> resp_rdata=3C. Next client 3 gets m_nack=1 -> resp_nack=1, resp_id=3.
- Timeout: TIMEOUT=64, model never pulses m_done -> resp_valid exactly 64 cycles after m_enable rises, resp_timeout=1, m_enable low next cycle.
- Race and mid-transfer change: m_done on the timeout terminal cycle -> timeout=0. Change req_data[0] during RUN -> m_data unchanged.
- Reset mid-RUN: assert rst for 1 cycle -> next cycle m_enable=0, gnt=0, no resp_valid. A subsequent req[0] is granted normally.
